// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;
  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic [1:0] {BOOT, RUN, FAULT} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch-side bus bundle: instruction memory port, redirect input and IF/ID handshake.
interface instruction_fetch_if;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic        fetch_fault;
  logic [31:0] perf_fetch_count;
  logic [31:0] perf_stall_count;

  modport master (
    output imem_pc, if_valid, if_instr, if_pc, fetch_fault,
           perf_fetch_count, perf_stall_count,
    input  imem_instr, redirect_valid, redirect_target, id_ready
  );

  modport slave (
    input  imem_pc, if_valid, if_instr, if_pc, fetch_fault,
           perf_fetch_count, perf_stall_count,
    output imem_instr, redirect_valid, redirect_target, id_ready
  );
endinterface

// File: rtl/instruction_fetch_pc_next.sv
// Next-PC selection: redirect beats sequential advance; misaligned redirects never load.
module fetch_pc_next
  import fetch_pkg::*;
(
  input  logic [31:0]  pc_q,
  input  fetch_state_t state,
  input  logic         fire,
  input  logic         redirect_valid,
  input  logic [31:0]  redirect_target,
  output logic [31:0]  pc_next,
  output logic         misalign
);

  always_comb begin
    pc_next  = pc_q;
    misalign = 1'b0;
    if (state == RUN) begin
      if (redirect_valid) begin
        misalign = (redirect_target[1:0] != 2'b00);
        if (!misalign) pc_next = redirect_target;
      end else if (fire) begin
        pc_next = pc_q + 32'(INSTR_BYTES);
      end
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: PC, IF/ID output register and redirect/fault handling.
// Optional performance counters are built when FETCH_PERF_EN is defined.
//
// state | meaning
// BOOT  | single idle cycle after reset release, outputs invalid
// RUN   | fetching, stalling on decode backpressure, taking redirects
// FAULT | misaligned redirect seen; frozen until reset
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH   = 32
) (
  input  logic clk,
  input  logic rst,
  instruction_fetch_if.master bus
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         misalign;
  logic         fire;
  logic [31:0]  fetch_word;
  logic         if_valid_q;
  logic [31:0]  if_instr_q;
  logic [31:0]  if_pc_q;
  logic         fault_q;

  assign fire = (state_q == RUN) && (!if_valid_q || bus.id_ready);

  // Words past the end of memory are fetched as NOPs rather than faulting.
  assign fetch_word = ({2'b00, pc_q[31:2]} >= 32'(IMEM_DEPTH)) ? NOP_INSTR : bus.imem_instr;

  fetch_pc_next u_pc_next (
    .pc_q            (pc_q),
    .state           (state_q),
    .fire            (fire),
    .redirect_valid  (bus.redirect_valid),
    .redirect_target (bus.redirect_target),
    .pc_next         (pc_d),
    .misalign        (misalign)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q    <= RESET_VECTOR;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      BOOT:    state_d = RUN;
      RUN:     if (misalign) state_d = FAULT;
      FAULT:   state_d = FAULT;
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if_valid_q <= 1'b0;
      if_instr_q <= NOP_INSTR;
      if_pc_q    <= 32'h0;
      fault_q    <= 1'b0;
    end else if (state_q == RUN) begin
      if (bus.redirect_valid) begin
        if_valid_q <= 1'b0;
        if (misalign) fault_q <= 1'b1;
      end else if (fire) begin
        if_valid_q <= 1'b1;
        if_instr_q <= fetch_word;
        if_pc_q    <= pc_q;
      end
    end else begin
      if_valid_q <= 1'b0;
    end
  end

  assign bus.imem_pc     = {2'b00, pc_q[31:2]};
  assign bus.if_valid    = if_valid_q;
  assign bus.if_instr    = if_instr_q;
  assign bus.if_pc       = if_pc_q;
  assign bus.fetch_fault = fault_q;

`ifdef FETCH_PERF_EN
  logic [31:0] fetch_cnt_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else if (if_valid_q) begin
      if (bus.id_ready) fetch_cnt_q <= fetch_cnt_q + 32'h1;
      else              stall_cnt_q <= stall_cnt_q + 32'h1;
    end
  end

  assign bus.perf_fetch_count = fetch_cnt_q;
  assign bus.perf_stall_count = stall_cnt_q;
`else
  assign bus.perf_fetch_count = 32'h0;
  assign bus.perf_stall_count = 32'h0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: boot, stall, redirect, wrap, fault and async reset.
module tb_instruction_fetch;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  instruction_fetch_if bus_a ();
  instruction_fetch_if bus_b ();

  instruction_fetch #(.RESET_VECTOR(32'h0000_0000), .IMEM_DEPTH(32)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a.master)
  );

  instruction_fetch #(.RESET_VECTOR(32'h0000_007C), .IMEM_DEPTH(32)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b.master)
  );

  // Word n holds 0x0010_0093 + n; anything past the 32-word array returns a marker.
  function automatic logic [31:0] mem_word(input logic [31:0] idx);
    return (idx < 32) ? (32'h0010_0093 + idx) : 32'hDEAD_BEEF;
  endfunction

  assign bus_a.imem_instr = mem_word(bus_a.imem_pc);
  assign bus_b.imem_instr = mem_word(bus_b.imem_pc);

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got=%h expected=%h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus_a.id_ready = 1'b1;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_target = 32'h0;
    bus_b.id_ready = 1'b1;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_target = 32'h0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(bus_a.if_valid), 32'h0);
    check("rst_instr", bus_a.if_instr, 32'h0000_0013);
    check("rst_pc", bus_a.if_pc, 32'h0);
    check("rst_fault", 32'(bus_a.fetch_fault), 32'h0);
    check("rst_imem_pc", bus_a.imem_pc, 32'h0);
    check("rst_perf_fetch", bus_a.perf_fetch_count, 32'h0);
    check("rst_perf_stall", bus_a.perf_stall_count, 32'h0);
    check("rst_imem_pc_b", bus_b.imem_pc, 32'h0000_001F);

    rst = 1'b0;
    step();
    check("boot_valid", 32'(bus_a.if_valid), 32'h0);
    check("boot_imem_pc", bus_a.imem_pc, 32'h0);

    step();
    check("f0_valid", 32'(bus_a.if_valid), 32'h1);
    check("f0_pc", bus_a.if_pc, 32'h0);
    check("f0_instr", bus_a.if_instr, 32'h0010_0093);
    check("f0_imem_pc", bus_a.imem_pc, 32'h1);
    check("b_last_pc", bus_b.if_pc, 32'h0000_007C);
    check("b_last_instr", bus_b.if_instr, 32'h0010_00B2);

    step();
    check("f1_pc", bus_a.if_pc, 32'h4);
    check("f1_instr", bus_a.if_instr, 32'h0010_0094);
    check("f1_imem_pc", bus_a.imem_pc, 32'h2);
    check("b_oor_pc", bus_b.if_pc, 32'h0000_0080);
    check("b_oor_instr", bus_b.if_instr, 32'h0000_0013);

    step();
    check("f2_pc", bus_a.if_pc, 32'h8);
    check("f2_instr", bus_a.if_instr, 32'h0010_0095);
    check("f2_imem_pc", bus_a.imem_pc, 32'h3);

    bus_a.id_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("stall_valid", 32'(bus_a.if_valid), 32'h1);
      check("stall_pc", bus_a.if_pc, 32'h8);
      check("stall_instr", bus_a.if_instr, 32'h0010_0095);
      check("stall_imem_pc", bus_a.imem_pc, 32'h3);
    end
`ifdef FETCH_PERF_EN
    check("perf_stall", bus_a.perf_stall_count, 32'd3);
    check("perf_fetch", bus_a.perf_fetch_count, 32'd2);
`else
    check("perf_stall_off", bus_a.perf_stall_count, 32'h0);
    check("perf_fetch_off", bus_a.perf_fetch_count, 32'h0);
`endif

    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_target = 32'h40;
    step();
    bus_a.redirect_valid = 1'b0;
    bus_a.id_ready = 1'b1;
    check("redir_flush", 32'(bus_a.if_valid), 32'h0);
    check("redir_imem_pc", bus_a.imem_pc, 32'h10);
    step();
    check("redir_valid", 32'(bus_a.if_valid), 32'h1);
    check("redir_pc", bus_a.if_pc, 32'h40);
    check("redir_instr", bus_a.if_instr, 32'h0010_00A3);

    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_target = 32'hFFFF_FFFC;
    step();
    bus_a.redirect_valid = 1'b0;
    check("top_flush", 32'(bus_a.if_valid), 32'h0);
    check("top_imem_pc", bus_a.imem_pc, 32'h3FFF_FFFF);
    step();
    check("top_pc", bus_a.if_pc, 32'hFFFF_FFFC);
    check("top_instr", bus_a.if_instr, 32'h0000_0013);
    step();
    check("wrap_pc", bus_a.if_pc, 32'h0);
    check("wrap_instr", bus_a.if_instr, 32'h0010_0093);

    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_target = 32'h42;
    step();
    check("mis_fault", 32'(bus_a.fetch_fault), 32'h1);
    check("mis_valid", 32'(bus_a.if_valid), 32'h0);
    check("mis_imem_pc", bus_a.imem_pc, 32'h1);
    for (int i = 0; i < 10; i++) begin
      bus_a.redirect_target = (i % 2 == 1) ? 32'h100 : 32'h43;
      bus_a.id_ready = (i % 2 == 1);
      step();
      check("fault_hold", 32'(bus_a.fetch_fault), 32'h1);
      check("fault_valid", 32'(bus_a.if_valid), 32'h0);
      check("fault_imem_pc", bus_a.imem_pc, 32'h1);
    end
    bus_a.redirect_valid = 1'b0;
    bus_a.id_ready = 1'b1;
    #2 rst = 1'b1;
    #1;
    check("fault_clear", 32'(bus_a.fetch_fault), 32'h0);
    check("fault_rst_valid", 32'(bus_a.if_valid), 32'h0);

    @(negedge clk);
    rst = 1'b0;
    step();
    check("boot2_valid", 32'(bus_a.if_valid), 32'h0);
    step();
    check("r2_valid", 32'(bus_a.if_valid), 32'h1);
    check("r2_pc", bus_a.if_pc, 32'h0);
    bus_a.id_ready = 1'b0;
    step();
    check("r2_stall_imem_pc", bus_a.imem_pc, 32'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("async_valid", 32'(bus_a.if_valid), 32'h0);
    check("async_instr", bus_a.if_instr, 32'h0000_0013);
    check("async_imem_pc", bus_a.imem_pc, 32'h0);

    @(negedge clk);
    rst = 1'b0;
    step();
    check("boot3_valid", 32'(bus_a.if_valid), 32'h0);
    bus_a.id_ready = 1'b1;
    step();
    check("r3_valid", 32'(bus_a.if_valid), 32'h1);
    check("r3_pc", bus_a.if_pc, 32'h0);
    check("r3_instr", bus_a.if_instr, 32'h0010_0093);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
